// File: rtl/multiport_reg_file_pkg.sv
// Shared types and defaults for the multiport register file.
// Used by the storage top, its busy scoreboard and the bus interface.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    function automatic int rfDepth(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/multiport_reg_file_if.sv
// Decode/writeback side bus of the register file: read, write and reserve.
// master = issue/writeback logic, slave = register file.
interface multiport_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] RdAddr;
    logic [NUM_RD*DATA_W-1:0] RdData;
    logic [NUM_RD-1:0]        RdBusy;
    logic [NUM_WR-1:0]        WrEn;
    logic [NUM_WR*ADDR_W-1:0] WrAddr;
    logic [NUM_WR*DATA_W-1:0] WrData;
    logic                     ResvEn;
    logic [ADDR_W-1:0]        ResvAddr;
    logic                     WrConflict;

    modport master (
        output RdAddr, WrEn, WrAddr, WrData, ResvEn, ResvAddr,
        input  RdData, RdBusy, WrConflict
    );

    modport slave (
        input  RdAddr, WrEn, WrAddr, WrData, ResvEn, ResvAddr,
        output RdData, RdBusy, WrConflict
    );

endinterface

// File: rtl/multiport_reg_file_scoreboard.sv
// Per-register busy bits: reserve sets, writeback clears, reserve wins a tie.
// Provides the raw busy bit of every read port's addressed register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_WR-1:0]        clrEn,
    input  logic [NUM_WR*ADDR_W-1:0] clrAddr,
    input  logic                     resvEn,
    input  logic [ADDR_W-1:0]        resvAddr,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD-1:0]        rdBusy
);

    localparam int DEPTH = rfDepth(ADDR_W);

    logic [DEPTH-1:0] busy;
    logic             resvEff;

    // Reserving the hardwired zero register has no effect.
    always_comb begin
        resvEff = resvEn && !(ZERO_REG != 0 && resvAddr == '0);
    end

    // Clears first, then the reserve, so a new producer supersedes the old one.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (clrEn[w]) begin
                    busy[clrAddr[w*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (resvEff) begin
                busy[resvAddr] <= 1'b1;
            end
        end
    end

    // Busy lookup for each read port.
    always_comb begin
        rdBusy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rdBusy[p] = busy[rdAddr[p*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Multiport register file with busy scoreboard and write-conflict flag.
// Optional RF_BYPASS_EN forwards same-cycle write data to the read ports.
module multiport_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input logic Clk,
    input logic Rst,
    multiport_reg_file_if.slave Bus
);

    localparam int DEPTH = rfDepth(ADDR_W);

    if (NUM_RD < 1 || NUM_RD > 4) begin : gBadRd
        $error("NUM_RD must be 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : gBadWr
        $error("NUM_WR must be 1..2");
    end
    if (ZERO_REG != 0 && ZERO_REG != 1) begin : gBadZero
        $error("ZERO_REG must be 0 or 1");
    end

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [NUM_WR-1:0]        wrEff;
    logic                     conflictNow;
    logic                     conflictQ;
    logic [NUM_RD-1:0]        sbBusy;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;

    // A write is effective unless it targets the hardwired zero register.
    always_comb begin
        wrEff = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wrEff[w] = Bus.WrEn[w] && !Rst &&
                !(ZERO_REG != 0 && Bus.WrAddr[w*ADDR_W +: ADDR_W] == '0);
        end
    end

    // Two or more effective writes to one address this cycle.
    always_comb begin
        conflictNow = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wrEff[i] && wrEff[j] &&
                    Bus.WrAddr[i*ADDR_W +: ADDR_W] ==
                    Bus.WrAddr[j*ADDR_W +: ADDR_W]) begin
                    conflictNow = 1'b1;
                end
            end
        end
    end

    // Storage; later ports are applied last so the highest index wins.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                regs[d] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wrEff[w]) begin
                    regs[Bus.WrAddr[w*ADDR_W +: ADDR_W]] <=
                        Bus.WrData[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // One-cycle conflict pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            conflictQ <= 1'b0;
        end else begin
            conflictQ <= conflictNow;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .Clk      (Clk),
        .Rst      (Rst),
        .clrEn    (wrEff),
        .clrAddr  (Bus.WrAddr),
        .resvEn   (Bus.ResvEn),
        .resvAddr (Bus.ResvAddr),
        .rdAddr   (Bus.RdAddr),
        .rdBusy   (sbBusy)
    );

    // Read muxes with optional forwarding from the write ports.
    always_comb begin
        rdData = '0;
        rdBusy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rdData[p*DATA_W +: DATA_W] = regs[Bus.RdAddr[p*ADDR_W +: ADDR_W]];
            rdBusy[p] = sbBusy[p];
`ifdef RF_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wrEff[w] && Bus.WrAddr[w*ADDR_W +: ADDR_W] ==
                    Bus.RdAddr[p*ADDR_W +: ADDR_W]) begin
                    rdData[p*DATA_W +: DATA_W] = Bus.WrData[w*DATA_W +: DATA_W];
                    rdBusy[p] = 1'b0;
                end
            end
`else
`endif
            if (ZERO_REG != 0 && Bus.RdAddr[p*ADDR_W +: ADDR_W] == '0) begin
                rdData[p*DATA_W +: DATA_W] = '0;
                rdBusy[p] = 1'b0;
            end
        end
    end

    assign Bus.RdData     = rdData;
    assign Bus.RdBusy     = rdBusy;
    assign Bus.WrConflict = conflictQ;

endmodule

// File: tb/tb_multiport_reg_file.sv
// Randomized and directed bench for multiport_reg_file against an array model.
// Honours RF_BYPASS_EN for same-cycle forwarding expectations.
module tb_multiport_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    // Free-running clock.
    always #5 Clk = ~Clk;

    multiport_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    multiport_reg_file #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .Bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mReg [DEPTH];
    bit            mBusy [DEPTH];
    bit            mConf;

    function automatic int wa(int w);
        return int'(bus.WrAddr[w*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] wd(int w);
        return bus.WrData[w*DW +: DW];
    endfunction

    function automatic int ra(int p);
        return int'(bus.RdAddr[p*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] rdData(int p);
        return bus.RdData[p*DW +: DW];
    endfunction

    task automatic modelClear();
        for (int a = 0; a < DEPTH; a++) begin
            mReg[a] = '0;
            mBusy[a] = 1'b0;
        end
        mConf = 1'b0;
    endtask

    // Architectural effect of one clock edge: last writer per address wins.
    task automatic modelStep();
        int cnt [DEPTH];
        if (Rst) begin
            modelClear();
            return;
        end
        for (int a = 0; a < DEPTH; a++) cnt[a] = 0;
        for (int w = 0; w < NW; w++) begin
            if (bus.WrEn[w] && wa(w) != 0) begin
                cnt[wa(w)]++;
                mReg[wa(w)] = wd(w);
                mBusy[wa(w)] = 1'b0;
            end
        end
        if (bus.ResvEn && bus.ResvAddr != '0) mBusy[bus.ResvAddr] = 1'b1;
        mConf = 1'b0;
        for (int a = 0; a < DEPTH; a++) if (cnt[a] > 1) mConf = 1'b1;
    endtask

    function automatic logic [DW-1:0] expData(int p);
        logic [DW-1:0] v;
        if (Rst || ra(p) == 0) return '0;
        v = mReg[ra(p)];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NW; w++)
            if (bus.WrEn[w] && wa(w) == ra(p)) v = wd(w);
`endif
        return v;
    endfunction

    function automatic bit expBusy(int p);
        bit b;
        if (Rst || ra(p) == 0) return 1'b0;
        b = mBusy[ra(p)];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NW; w++)
            if (bus.WrEn[w] && wa(w) == ra(p)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic setRd(int p, int a);
        bus.RdAddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic setWr(int w, bit en, int a, logic [DW-1:0] d);
        bus.WrEn[w] = en;
        bus.WrAddr[w*AW +: AW] = AW'(a);
        bus.WrData[w*DW +: DW] = d;
    endtask

    task automatic idle();
        bus.WrEn = '0;
        bus.WrAddr = '0;
        bus.WrData = '0;
        bus.ResvEn = 1'b0;
        bus.ResvAddr = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        modelStep();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        idle();
        bus.RdAddr = '0;
        modelClear();
        setRd(0, 5);
        setRd(1, 9);
        #2;
        checks++;
        if (bus.RdData !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", bus.RdData);
        end
        checks++;
        if (bus.RdBusy !== '0 || bus.WrConflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b conf=%b want 0/0", bus.RdBusy, bus.WrConflict);
        end
        @(negedge Clk);
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        setWr(0, 1, 5, 32'hDEADBEEF);
        bus.ResvEn = 1'b1;
        bus.ResvAddr = 5'd6;
        tick();
        idle();
        setRd(0, 5);
        setRd(1, 6);
        #1;
        checks++;
        if (rdData(0) !== 32'hDEADBEEF || bus.RdBusy[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got %h busy=%b want deadbeef busy=1", rdData(0), bus.RdBusy[1]);
        end
        setWr(0, 1, 7, 32'h1);
        setWr(1, 1, 7, 32'h2);
        tick();
        setWr(0, 1, 5, 32'h77);
        bus.ResvEn = 1'b1;
        bus.ResvAddr = 5'd5;
        #1;
        Rst = 1'b1;
        modelClear();
        #1;
        checks++;
        if (bus.RdData !== '0 || bus.RdBusy !== '0 || bus.WrConflict !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got data=%h busy=%b conf=%b want 0", bus.RdData, bus.RdBusy, bus.WrConflict);
        end
        tick();
        idle();
        Rst = 1'b0;
        #1;
        checks++;
        if (rdData(0) !== '0 || bus.RdBusy !== '0) begin
            errors++;
            $display("FAIL post_reset got %h busy=%b want 0", rdData(0), bus.RdBusy);
        end
    endtask

    task automatic test_conflict();
        setWr(0, 1, 7, 32'h11);
        setWr(1, 1, 7, 32'h22);
        tick();
        idle();
        setRd(0, 7);
        #1;
        checks++;
        if (rdData(0) !== 32'h22 || bus.WrConflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict got %h conf=%b want 22 conf=1", rdData(0), bus.WrConflict);
        end
        tick();
        checks++;
        if (bus.WrConflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_pulse got %b want 0", bus.WrConflict);
        end
        setWr(0, 1, 8, 32'h1);
        setWr(1, 1, 9, 32'h2);
        tick();
        idle();
        checks++;
        if (bus.WrConflict !== 1'b0) begin
            errors++;
            $display("FAIL no_conflict got %b want 0", bus.WrConflict);
        end
    endtask

    task automatic test_zero_reg();
        setWr(0, 1, 0, 32'hFFFF_FFFF);
        setWr(1, 1, 0, 32'hFFFF_FFFF);
        bus.ResvEn = 1'b1;
        bus.ResvAddr = '0;
        setRd(0, 0);
        #1;
        checks++;
        if (rdData(0) !== '0) begin
            errors++;
            $display("FAIL zero_bypass got %h want 0", rdData(0));
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdData(0) !== '0 || bus.RdBusy[0] !== 1'b0 || bus.WrConflict !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg got %h busy=%b conf=%b want 0", rdData(0), bus.RdBusy[0], bus.WrConflict);
        end
    endtask

    task automatic test_scoreboard();
        bus.ResvEn = 1'b1;
        bus.ResvAddr = 5'd3;
        tick();
        idle();
        setRd(0, 3);
        #1;
        checks++;
        if (bus.RdBusy[0] !== 1'b1) begin
            errors++;
            $display("FAIL resv_busy got %b want 1", bus.RdBusy[0]);
        end
        setWr(1, 1, 3, 32'h55);
        tick();
        idle();
        #1;
        checks++;
        if (bus.RdBusy[0] !== 1'b0 || rdData(0) !== 32'h55) begin
            errors++;
            $display("FAIL wb_clear got busy=%b %h want 0 55", bus.RdBusy[0], rdData(0));
        end
        setWr(0, 1, 3, 32'h66);
        bus.ResvEn = 1'b1;
        bus.ResvAddr = 5'd3;
        tick();
        idle();
        #1;
        checks++;
        if (bus.RdBusy[0] !== 1'b1 || rdData(0) !== 32'h66) begin
            errors++;
            $display("FAIL resv_wins got busy=%b %h want 1 66", bus.RdBusy[0], rdData(0));
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] wantD;
        bit            wantB;
        setWr(0, 1, 9, 32'h1234);
        tick();
        bus.WrEn = '0;
        bus.ResvEn = 1'b1;
        bus.ResvAddr = 5'd9;
        tick();
        idle();
        setWr(1, 1, 9, 32'hA5A5);
        setRd(0, 9);
        setRd(1, 9);
        #1;
`ifdef RF_BYPASS_EN
        wantD = 32'hA5A5;
        wantB = 1'b0;
`else
        wantD = 32'h1234;
        wantB = 1'b1;
`endif
        checks++;
        if (rdData(0) !== wantD || rdData(1) !== wantD) begin
            errors++;
            $display("FAIL bypass_data got %h/%h want %h", rdData(0), rdData(1), wantD);
        end
        checks++;
        if (bus.RdBusy !== {NR{wantB}}) begin
            errors++;
            $display("FAIL bypass_busy got %b want %b", bus.RdBusy, {NR{wantB}});
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdData(1) !== 32'hA5A5 || bus.RdBusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after got %h busy=%b want a5a5 0", rdData(1), bus.RdBusy[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            for (int w = 0; w < NW; w++) begin
                setWr(w, $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)), $urandom);
            end
            bus.ResvEn = $urandom_range(0, 2) == 0;
            bus.ResvAddr = AW'($urandom_range(0, 7));
            for (int p = 0; p < NR; p++) setRd(p, int'($urandom_range(0, 8)));
            if ($urandom_range(0, 499) == 0) begin
                Rst = 1'b1;
                modelClear();
            end
            #1;
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rdData(p) !== expData(p)) begin
                    errors++;
                    $display("FAIL rand_data c=%0d p=%0d got %h want %h", c, p, rdData(p), expData(p));
                end
                checks++;
                if (bus.RdBusy[p] !== expBusy(p)) begin
                    errors++;
                    $display("FAIL rand_busy c=%0d p=%0d got %b want %b", c, p, bus.RdBusy[p], expBusy(p));
                end
            end
            checks++;
            if (bus.WrConflict !== mConf) begin
                errors++;
                $display("FAIL rand_conf c=%0d got %b want %b", c, bus.WrConflict, mConf);
            end
            tick();
            Rst = 1'b0;
        end
        idle();
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_reset_midstream();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
